seq_detector_1011: RTL and testbench
====================================

# seq_detector_1011

Serial pattern detector that sits directly downstream of the `d_flip_flop` stage and consumes its registered `Q` output as a one-bit-per-clock stream. A Moore-style FSM recognises the pattern 1011, MSB first, with selectable overlap. It emits a one-cycle registered detect pulse and keeps a saturating count of matches for the lab's seven-segment and LED display logic.

## Interface
- `OVERLAP`, default 1: 1 means a match may share its trailing bits with the next match; 0 means the FSM restarts after each match.
- `CNT_W`, default 8: width of the match counter.

- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  reset, synchronous, active-low; sampled only on the rising edge of `CLK`.
- `EN`  in  1  stream-valid qualifier; `DIN` is consumed only on edges where `EN`=1.
- `DIN`  in  1  serial data bit, normally the `Q` output of the upstream flip-flop.
- `CLR`  in  1  synchronous counter clear, active-high; it does not affect the FSM.
- `DET`  out  1  registered one-cycle pulse marking a completed 1011.
- `COUNT`  out  `CNT_W`  number of matches, saturating at 2^`CNT_W`−1.
- `STATE`  out  3  current FSM state encoding, for debug and LEDs.

## Operation
- FSM state encodings:
  - S0 = 0: no useful prefix.
  - S1 = 1: seen "1".
  - S10 = 2: seen "10".
  - S101 = 3: seen "101".
  - S1011 = 4: match.
- Transitions, applied only when `EN`=1 (listed as DIN=0 / DIN=1):
  - S0 → S0 / S1
  - S1 → S10 / S1
  - S10 → S0 / S101
  - S101 → S10 / S1011
  - S1011 with `OVERLAP`=1 → S10 / S1
  - S1011 with `OVERLAP`=0 → S0 / S1
- When `EN`=0 the state holds, `DIN` is ignored, and `DET` is 0 on the next edge.
- `DET` is registered. It is set to 1 on an edge where `EN`=1 and the next state is S1011; otherwise it is cleared to 0. `DET` is therefore never high for two consecutive cycles.
- `COUNT` increments by 1 on the same edge that sets `DET`, unless it is already at the all-ones value, in which case it holds (saturates, no wrap).
- `CLR` and a match on the same edge: `CLR` wins, so `COUNT` becomes 0 and the match is not counted. `DET` still pulses.
- Unused encodings 5–7 recover to S0 on the next edge regardless of `EN`, with `DET`=0.
- Reset (`RST`=0 at an edge) overrides everything, including when asserted mid-pattern:
  - FSM goes to S0.
  - `DET` goes to 0.
  - `COUNT` goes to 0.
  - `STATE` reads 0.

## Timing
- Reset values: `STATE`=0, `DET`=0, `COUNT`=0.
- Latency: if the final '1' of the pattern is sampled at edge k, `DET`=1 and the updated `COUNT` are visible from edge k until edge k+1.
- Minimum spacing between `DET` pulses:
  - `OVERLAP`=1: 3 enabled bits ("1011011" yields matches at bits 4 and 7).
  - `OVERLAP`=0: 4 enabled bits.
- No combinational path from `DIN` to any output; all outputs come straight from flops.
- Upstream flip-flop output changes only on `CLK` edges. `DIN` must be stable around the rising edge, which holds when the same `CLK` drives both stages.

## Structure
- Shared package/include `seq_det_pkg`:
  - state localparams S0, S1, S10, S101, S1011;
  - `STATE_W`=3;
  - pattern constant 4'b1011.
- One natural sub-module, `sat_counter`:
  - parameter `CNT_W`;
  - inputs `CLK`, `RST`, `CLR`, `INC`;
  - output `COUNT`;
  - saturating, with `CLR` priority over `INC`.
- Top level holds the FSM next-state logic, the state register and the `DET` flop.

## Test plan
- **Reset mid-pattern:** feed 1,0,1, then `RST`=0 for one edge, then 1 → `STATE`=0 after the reset edge, no `DET`, `COUNT`=0; the trailing 1 only reaches S1.
- **Overlap on:** `OVERLAP`=1, `EN`=1, stream 1,0,1,1,0,1,1 → `DET` pulses after bits 4 and 7, `COUNT`=2.
- **Overlap off:** `OVERLAP`=0, same stream → single `DET` after bit 4, `COUNT`=1.
- **Enable gaps:** 1,0 (`EN`=1), three edges with `EN`=0 and `DIN`=0, then 1,1 (`EN`=1) → `STATE` stays 2 during the gap; `DET` after the final bit; `COUNT`=1.
- **Saturation:** `CNT_W`=2, stream "1011" repeated five times with `OVERLAP`=0 → `COUNT` reads 1,2,3,3,3; `DET` still pulses five times.
- **CLR collision:** assert `CLR` on the edge of a match with `COUNT`=5 → `COUNT`=0, `DET`=1; the next match gives `COUNT`=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 serial pattern detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_det_pkg;

    localparam int STATE_W = 3;

    // Pattern recognised, MSB first on the serial stream.
    localparam logic [3:0] PATTERN = 4'b1011;

    // FSM state encodings are visible on the STATE debug/LED output, so
    // they are fixed explicitly rather than left to the tool.
    typedef enum logic [STATE_W-1:0] {
        S0    = 3'd0,   // no useful prefix
        S1    = 3'd1,   // seen "1"
        S10   = 3'd2,   // seen "10"
        S101  = 3'd3,   // seen "101"
        S1011 = 3'd4    // full match
    } state_e;

    // True for the five legal encodings; 5..7 are recovery-only.
    function automatic logic state_is_legal(input logic [STATE_W-1:0] s);
        return (s <= 3'd4);
    endfunction

endpackage

// File: rtl/seq_detector_1011_if.sv
// Stream-in / status-out bundle between the bit source and the detector.
// Latency: n/a (wiring only).
// Backpressure: none; EN qualifies each bit, the detector always accepts.
interface seq_detector_1011_if #(
    parameter int CNT_W = 8
);
    // Stream side: driven by the upstream flip-flop / control logic.
    logic                              EN;
    logic                              DIN;
    logic                              CLR;

    // Status side: driven by the detector, all straight from flops.
    logic                              DET;
    logic [CNT_W-1:0]                  COUNT;
    logic [seq_det_pkg::STATE_W-1:0]   STATE;

    modport master (
        output EN,
        output DIN,
        output CLR,
        input  DET,
        input  COUNT,
        input  STATE
    );

    modport slave (
        input  EN,
        input  DIN,
        input  CLR,
        output DET,
        output COUNT,
        output STATE
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating match counter with synchronous clear.
// Latency: COUNT updates on the edge INC/CLR is sampled.
// Backpressure: none; at all-ones further INCs are dropped, CLR beats INC.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             INC,
    output logic [CNT_W-1:0] COUNT
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == {CNT_W{1'b1}});

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (INC && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign COUNT = cnt_q;

endmodule

// File: rtl/seq_detector_1011.sv
// Moore FSM spotting 1011 on a qualified serial stream, with match counter.
// Latency: DET/COUNT valid from the edge sampling the final '1' for one cycle.
// Backpressure: none; EN=0 freezes the FSM and forces DET low next edge.
module seq_detector_1011
    import seq_det_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    seq_detector_1011_if.slave   bus
);

    state_e           state_q;
    state_e           state_d;
    logic             det_q;
    logic             det_d;
    logic [CNT_W-1:0] count_w;

    // Where to go after a completed match: with overlap the trailing "1"
    // or "10" of 1011 is reused as the start of the next pattern.
    state_e after_match_0;
    assign after_match_0 = (OVERLAP != 0) ? S10 : S0;

    // Next-state and detect decode; illegal encodings fall back to S0.
    always_comb begin
        state_d = state_q;
        det_d   = 1'b0;
        if (!state_is_legal(state_q)) begin
            state_d = S0;
        end else if (bus.EN) begin
            case (state_q)
                S0:      state_d = bus.DIN ? S1    : S0;
                S1:      state_d = bus.DIN ? S1    : S10;
                S10:     state_d = bus.DIN ? S101  : S0;
                S101:    state_d = bus.DIN ? S1011 : S10;
                S1011:   state_d = bus.DIN ? S1    : after_match_0;
                default: state_d = S0;
            endcase
            det_d = (state_d == S1011);
        end
    end

    // State and detect-pulse registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
        end
    end

    // Counter bumps on the same edge that raises DET.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (bus.CLR),
        .INC   (det_d),
        .COUNT (count_w)
    );

    assign bus.DET   = det_q;
    assign bus.STATE = state_q;
    assign bus.COUNT = count_w;

endmodule

// File: tb/tb_seq_detector_1011.sv
// Bench for seq_detector_1011: three configurations driven by one stream,
// checked every cycle against a bit-history reference model.
// Directed test-plan scenarios followed by randomized traffic.
module tb_seq_detector_1011;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic din   = 1'b0;
    logic clr   = 1'b0;

    // 0: overlap, 8-bit count; 1: no overlap, 8-bit; 2: no overlap, 2-bit.
    seq_detector_1011_if #(.CNT_W(8)) if_ov  ();
    seq_detector_1011_if #(.CNT_W(8)) if_nov ();
    seq_detector_1011_if #(.CNT_W(2)) if_sat ();

    assign if_ov.EN   = en;  assign if_ov.DIN  = din; assign if_ov.CLR  = clr;
    assign if_nov.EN  = en;  assign if_nov.DIN = din; assign if_nov.CLR = clr;
    assign if_sat.EN  = en;  assign if_sat.DIN = din; assign if_sat.CLR = clr;

    seq_detector_1011 #(.OVERLAP(1), .CNT_W(8)) dut_ov  (.CLK(CLK), .RST(rst_n), .bus(if_ov));
    seq_detector_1011 #(.OVERLAP(0), .CNT_W(8)) dut_nov (.CLK(CLK), .RST(rst_n), .bus(if_nov));
    seq_detector_1011 #(.OVERLAP(0), .CNT_W(2)) dut_sat (.CLK(CLK), .RST(rst_n), .bus(if_sat));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per configuration, the last few enabled bits seen
    // since reset (or since the previous match when overlap is off).
    int         ov_cfg [3] = '{1, 0, 0};
    int         max_cfg[3] = '{255, 255, 3};
    logic [3:0] hbits  [3];
    int         hlen   [3];
    int         exp_state[3];
    int         exp_det  [3];
    int         exp_cnt  [3];
    logic [3:0] pat = 4'b1011;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Longest tail of the history that is also a leading part of 1011.
    function automatic int prefix_len(input logic [3:0] h, input int len);
        for (int l = len; l >= 1; l--) begin
            bit ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (h[l-1-i] != pat[3-i]) ok = 1'b0;
            end
            if (ok) return l;
        end
        return 0;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                hbits[k] = '0; hlen[k] = 0;
                exp_state[k] = 0; exp_det[k] = 0; exp_cnt[k] = 0;
            end else begin
                int m = 0;
                if (en) begin
                    int pl;
                    hbits[k] = {hbits[k][2:0], din};
                    if (hlen[k] < 4) hlen[k]++;
                    pl = prefix_len(hbits[k], hlen[k]);
                    exp_state[k] = pl;
                    if (pl == 4) begin
                        m = 1;
                        if (ov_cfg[k] == 0) hlen[k] = 0;
                    end
                end
                exp_det[k] = m;
                if (clr) exp_cnt[k] = 0;
                else if (m == 1 && exp_cnt[k] < max_cfg[k]) exp_cnt[k]++;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("ov.STATE",  int'(if_ov.STATE),  exp_state[0]);
        check_eq("ov.DET",    int'(if_ov.DET),    exp_det[0]);
        check_eq("ov.COUNT",  int'(if_ov.COUNT),  exp_cnt[0]);
        check_eq("nov.STATE", int'(if_nov.STATE), exp_state[1]);
        check_eq("nov.DET",   int'(if_nov.DET),   exp_det[1]);
        check_eq("nov.COUNT", int'(if_nov.COUNT), exp_cnt[1]);
        check_eq("sat.STATE", int'(if_sat.STATE), exp_state[2]);
        check_eq("sat.DET",   int'(if_sat.DET),   exp_det[2]);
        check_eq("sat.COUNT", int'(if_sat.COUNT), exp_cnt[2]);
    endtask

    task automatic step(input bit r, input bit e, input bit d, input bit c);
        @(negedge CLK);
        rst_n = r; en = e; din = d; clr = c;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, bits[n-1-i], 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();
        check_eq("reset.STATE", int'(if_ov.STATE), 0);
        check_eq("reset.COUNT", int'(if_ov.COUNT), 0);

        // Reset mid-pattern: 1,0,1 then reset, then a lone 1 reaches S1 only.
        feed(16'b101, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("midrst.STATE", int'(if_ov.STATE), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("midrst.after1", int'(if_ov.STATE), 1);
        check_eq("midrst.DET",    int'(if_ov.DET),   0);

        // Overlapping stream 1011011: two matches with overlap, one without.
        do_reset();
        feed(16'b1011011, 7);
        check_eq("ovl.on.COUNT",  int'(if_ov.COUNT),  2);
        check_eq("ovl.off.COUNT", int'(if_nov.COUNT), 1);

        // Enable gap: state holds at S10 while EN=0.
        do_reset();
        feed(16'b10, 2);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check_eq("gap.STATE", int'(if_ov.STATE), 2);
        end
        feed(16'b11, 2);
        check_eq("gap.DET",   int'(if_ov.DET),   1);
        check_eq("gap.COUNT", int'(if_ov.COUNT), 1);

        // Saturation on the 2-bit counter, plus CLR colliding with a match.
        do_reset();
        for (int i = 0; i < 5; i++) feed(16'b1011, 4);
        check_eq("sat.final", int'(if_sat.COUNT), 3);
        check_eq("nov.five",  int'(if_nov.COUNT), 5);
        feed(16'b101, 3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("clr.COUNT", int'(if_nov.COUNT), 0);
        check_eq("clr.DET",   int'(if_nov.DET),   1);
        feed(16'b1011, 4);
        check_eq("clr.next",  int'(if_nov.COUNT), 1);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
